// File: rtl/radix2_sdf_stage32_pkg.sv
// Shared constants and the 24-bit saturation helper for the radix-2 SDF stage.
//   DATA_W  sample width (signed Q16.8)
//   FRAC_W  fractional bits removed after a multiply
//   N, D    transform length and feedback delay depth
//   WIDE_W  widest intermediate handled by sat24 (full complex-multiply sum)
package radix2_sdf_stage32_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 8;
  localparam int N      = 32;
  localparam int D      = 16;
  localparam int WIDE_W = 2 * DATA_W + 1;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_DRAIN  = 1'b1
  } stage_state_e;

  // Clamp a sign-extended value to [-2^23, 2^23-1]. The value fits when all
  // bits from the top down to bit DATA_W-1 agree.
  function automatic logic [DATA_W-1:0] sat24(input logic [WIDE_W-1:0] x);
    logic [WIDE_W-DATA_W:0] top;
    top = x[WIDE_W-1:DATA_W-1];
    if ((&top) || (~|top)) begin
      sat24 = x[DATA_W-1:0];
    end else if (x[WIDE_W-1]) begin
      sat24 = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat24 = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/radix2_sdf_stage32_cmul_q8.sv
// Complex multiply of two signed Q16.8 values, full precision, floor shift by
// FRAC_W, saturated back to 24 bits. Purely combinational.
//   dr, di  data real / imaginary
//   wr, wi  twiddle real / imaginary (used as supplied, no conjugation)
//   pr, pi  product real / imaginary
module cmul_q8
  import radix2_sdf_stage32_pkg::*;
(
  input  logic [DATA_W-1:0] dr,
  input  logic [DATA_W-1:0] di,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wi,
  output logic [DATA_W-1:0] pr,
  output logic [DATA_W-1:0] pi
);

  logic signed [2*DATA_W-1:0] dr_x, di_x, wr_x, wi_x;
  logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [WIDE_W-1:0]   re_full, im_full, re_shift, im_shift;

  always_comb begin
    // Operands widened to the product width so the 48-bit products are exact.
    dr_x = {{DATA_W{dr[DATA_W-1]}}, dr};
    di_x = {{DATA_W{di[DATA_W-1]}}, di};
    wr_x = {{DATA_W{wr[DATA_W-1]}}, wr};
    wi_x = {{DATA_W{wi[DATA_W-1]}}, wi};
    p_rr = dr_x * wr_x;
    p_ii = di_x * wi_x;
    p_ri = dr_x * wi_x;
    p_ir = di_x * wr_x;
    re_full  = {p_rr[2*DATA_W-1], p_rr} - {p_ii[2*DATA_W-1], p_ii};
    im_full  = {p_ri[2*DATA_W-1], p_ri} + {p_ir[2*DATA_W-1], p_ir};
    re_shift = re_full >>> FRAC_W;
    im_shift = im_full >>> FRAC_W;
    pr = sat24(re_shift);
    pi = sat24(im_shift);
  end

endmodule

// File: rtl/radix2_sdf_stage32.sv
// Radix-2 DIF single-delay-feedback stage, N=32, 16-deep complex feedback.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready drops only while draining
//   din_r, din_i        input sample (signed Q16.8)
//   tw_idx              twiddle index requested this cycle (= count[3:0])
//   w_r, w_i            twiddle for tw_idx, same cycle
//   out_valid           registered output strobe
//   dout_r, dout_i      registered output sample, held when out_valid=0
//
// state     | meaning
// ST_STREAM | accepting samples; stalls whenever in_valid is low mid-frame
// ST_DRAIN  | flushing stored differences with zero input, in_ready low
//
// A drain starts in the first cycle after a wrap where in_valid is low; that
// cycle is already a drain cycle, so in_ready falls combinationally with it.
module radix2_sdf_stage32
  import radix2_sdf_stage32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] din_r,
  input  logic [23:0] din_i,
  output logic [3:0]  tw_idx,
  input  logic [23:0] w_r,
  input  logic [23:0] w_i,
  output logic        out_valid,
  output logic [23:0] dout_r,
  output logic [23:0] dout_i
);

  stage_state_e      state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic              primed_q, primed_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;
  logic [DATA_W-1:0] dl_r_q [D];
  logic [DATA_W-1:0] dl_i_q [D];
  logic [DATA_W-1:0] dl_r_d [D];
  logic [DATA_W-1:0] dl_i_d [D];

  logic              drain_start, draining, advance, phase_b;
  logic [DATA_W-1:0] x_r, x_i, head_r, head_i, push_r, push_i;
  logic [DATA_W-1:0] tw_r_prod, tw_i_prod;
  logic [DATA_W:0]   sum_r, sum_i, dif_r, dif_i;

  assign drain_start = (state_q == ST_STREAM) && primed_q && (count_q == 5'd0) && !in_valid;
  assign draining    = (state_q == ST_DRAIN) || drain_start;
  assign in_ready    = !draining;
  assign advance     = (in_valid && in_ready) || draining;
  assign phase_b     = count_q[4];
  assign tw_idx      = count_q[3:0];

  assign x_r    = draining ? '0 : din_r;
  assign x_i    = draining ? '0 : din_i;
  assign head_r = dl_r_q[D-1];
  assign head_i = dl_i_q[D-1];

  assign sum_r = {head_r[DATA_W-1], head_r} + {x_r[DATA_W-1], x_r};
  assign sum_i = {head_i[DATA_W-1], head_i} + {x_i[DATA_W-1], x_i};
  assign dif_r = {head_r[DATA_W-1], head_r} - {x_r[DATA_W-1], x_r};
  assign dif_i = {head_i[DATA_W-1], head_i} - {x_i[DATA_W-1], x_i};

  cmul_q8 u_cmul (
    .dr (head_r),
    .di (head_i),
    .wr (w_r),
    .wi (w_i),
    .pr (tw_r_prod),
    .pi (tw_i_prod)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    push_r      = x_r;
    push_i      = x_i;
    for (int i = 0; i < D; i++) begin
      dl_r_d[i] = dl_r_q[i];
      dl_i_d[i] = dl_i_q[i];
    end
    if (advance) begin
      count_d = count_q + 5'd1;
      if (phase_b) begin
        push_r      = sat24({{(WIDE_W-DATA_W-1){dif_r[DATA_W]}}, dif_r});
        push_i      = sat24({{(WIDE_W-DATA_W-1){dif_i[DATA_W]}}, dif_i});
        dout_r_d    = sat24({{(WIDE_W-DATA_W-1){sum_r[DATA_W]}}, sum_r});
        dout_i_d    = sat24({{(WIDE_W-DATA_W-1){sum_i[DATA_W]}}, sum_i});
        out_valid_d = 1'b1;
      end else if (primed_q) begin
        dout_r_d    = tw_r_prod;
        dout_i_d    = tw_i_prod;
        out_valid_d = 1'b1;
      end
      dl_r_d[0] = push_r;
      dl_i_d[0] = push_i;
      for (int i = 1; i < D; i++) begin
        dl_r_d[i] = dl_r_q[i-1];
        dl_i_d[i] = dl_i_q[i-1];
      end
      if (count_q == 5'(N-1)) begin
        primed_d = 1'b1;
      end
      // Drain ends after the last stored difference; next frame restarts at 0.
      if (draining && (count_q == 5'(D-1))) begin
        count_d  = 5'd0;
        primed_d = 1'b0;
        state_d  = ST_STREAM;
      end else if (drain_start) begin
        state_d = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STREAM;
      count_q     <= 5'd0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  // Storage is deliberately unreset; primed gates anything stale.
  always_ff @(posedge clk) begin
    dl_r_q <= dl_r_d;
    dl_i_q <= dl_i_d;
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule
